// File: rtl/uart_rx_16x.sv
// rtl/uart_rx_16x.sv - 16x-oversampling 8N1 UART receiver with valid/ready output
module uart_rx_16x #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cfg_divider,
  input  logic        rx,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        rx_frame_err,
  output logic        rx_overrun,
  output logic        rx_busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK_WAIT} state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;
  logic [31:0]            div_cnt;
  logic                   disabled, tick;
  logic [2:0]             hist;
  logic                   maj;
  logic [3:0]             os_cnt, os_n;
  logic [2:0]             bit_cnt, bit_n;
  logic [7:0]             shreg, sh_n;
  logic                   deliver, ferr;

  assign rx_s     = sync_q[SYNC_STAGES-1];
  assign disabled = (cfg_divider == 32'hFFFF_FFFF);
  assign tick     = !disabled && (div_cnt >= cfg_divider);
  assign maj      = (hist[0] & hist[1]) | (hist[0] & hist[2]) | (hist[1] & hist[2]);
  assign rx_busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= '1;
      div_cnt <= '0;
      hist    <= 3'b111;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
      if (disabled || tick) div_cnt <= '0;
      else                  div_cnt <= div_cnt + 32'd1;
      if (tick) hist <= {hist[1:0], rx_s};
    end
  end

  always_comb begin
    state_n = state;
    os_n    = os_cnt;
    bit_n   = bit_cnt;
    sh_n    = shreg;
    deliver = 1'b0;
    ferr    = 1'b0;
    if (disabled) begin
      state_n = IDLE;
    end else if (tick) begin
      case (state)
        IDLE: if (!rx_s) begin
          state_n = START;
          os_n    = 4'd0;
        end
        START: if (os_cnt == 4'd7) begin
          if (maj) state_n = IDLE;
          else begin
            state_n = DATA;
            os_n    = 4'd0;
            bit_n   = 3'd0;
          end
        end else os_n = os_cnt + 4'd1;
        DATA: if (os_cnt == 4'd15) begin
          sh_n = {maj, shreg[7:1]};
          os_n = 4'd0;
          if (bit_cnt == 3'd7) state_n = STOP;
          else                 bit_n   = bit_cnt + 3'd1;
        end else os_n = os_cnt + 4'd1;
        STOP: if (os_cnt == 4'd15) begin
          if (maj) begin
            deliver = 1'b1;
            state_n = IDLE;
          end else begin
            ferr    = 1'b1;
            state_n = BRK_WAIT;
          end
        end else os_n = os_cnt + 4'd1;
        BRK_WAIT: if (rx_s) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      os_cnt       <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      state        <= state_n;
      os_cnt       <= os_n;
      bit_cnt      <= bit_n;
      shreg        <= sh_n;
      rx_frame_err <= ferr;
      rx_overrun   <= 1'b0;
      // a byte completing in the same cycle as an accept replaces the old one
      if (deliver && (!rx_valid || rx_ready)) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else begin
        if (deliver) rx_overrun <= 1'b1;
        if (rx_valid && rx_ready) rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_16x.sv
// tb/tb_uart_rx_16x.sv - scoreboard bench for uart_rx_16x
module tb_uart_rx_16x;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cfg_divider;
  logic        rx;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        rx_frame_err;
  logic        rx_overrun;
  logic        rx_busy;

  int checks = 0;
  int failures = 0;
  int loads = 0, fe_cnt = 0, ov_cnt = 0, run = 0, max_run = 0;
  int loads0, fe0, ov0;
  logic [7:0] sbq[$];
  logic [7:0] exp_b;
  logic       prev_valid = 1'b0, prev_acc = 1'b0, load_seen;

  uart_rx_16x #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .cfg_divider(cfg_divider), .rx(rx),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Frame bit i, clock c is driven 1 time unit after edge E0 + i*bitclks + c.
  task automatic send_byte(input logic [7:0] d, input logic stop, input int bitclks,
                           input int spike_bit, input int spike_pos);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < bitclks; c++) begin
        @(posedge clk); #1;
        rx = fr[i] ^ ((i == spike_bit) && (c == spike_pos));
      end
    end
  endtask

  task automatic drain();
    rx_ready = 1'b1;
    @(posedge clk); #1;
    rx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
      prev_acc   = 1'b0;
      run        = 0;
    end else begin
      if (rx_frame_err) fe_cnt++;
      if (rx_overrun)   ov_cnt++;
      load_seen = rx_valid && (!prev_valid || prev_acc);
      if (load_seen) begin
        loads++;
        checks++;
        assert (sbq.size() > 0) else begin
          failures++;
          $error("FAIL sb_unexpected observed=%0h expected=none", rx_data);
        end
        if (sbq.size() > 0) begin
          exp_b = sbq.pop_front();
          checks++;
          assert (rx_data === exp_b) else begin
            failures++;
            $error("FAIL sb_data observed=%0h expected=%0h", rx_data, exp_b);
          end
        end
      end
      run = load_seen ? 1 : (rx_valid ? run + 1 : 0);
      if (run > max_run) max_run = run;
      prev_valid = rx_valid;
      prev_acc   = rx_valid && rx_ready;
    end
  end

  initial begin
    reset = 1'b1; cfg_divider = 32'd0; rx = 1'b1; rx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", rx_data, 8'h00);
    chk("rst_valid", rx_valid, 1'b0);
    chk("rst_ferr", rx_frame_err, 1'b0);
    chk("rst_ovr", rx_overrun, 1'b0);
    chk("rst_busy", rx_busy, 1'b0);
    reset = 1'b0;
    repeat (4) @(posedge clk);

    // clean frame: stop-sample tick is the cycle after E154, valid at E155
    sbq.push_back(8'hA5);
    fork
      send_byte(8'hA5, 1'b1, 16, -1, 0);
      begin
        @(posedge clk);
        repeat (154) @(posedge clk);
        #1;
        chk("clean_valid_early", rx_valid, 1'b0);
        chk("clean_busy_stop", rx_busy, 1'b1);
        @(posedge clk); #1;
        chk("clean_valid", rx_valid, 1'b1);
        chk("clean_data", rx_data, 8'hA5);
        chk("clean_ferr", rx_frame_err, 1'b0);
        chk("clean_ovr", rx_overrun, 1'b0);
      end
    join
    drain();

    // 9600 baud, back-to-back with consumer always ready
    cfg_divider = 32'd162; rx_ready = 1'b1;
    loads0 = loads; max_run = 0;
    sbq.push_back(8'h41);
    send_byte(8'h41, 1'b1, 2608, -1, 0);
    sbq.push_back(8'h0D);
    send_byte(8'h0D, 1'b1, 2608, -1, 0);
    repeat (50) @(posedge clk);
    #1;
    chk("baud_loads", loads - loads0, 2);
    chk("baud_valid_1clk", max_run, 1);
    chk("baud_valid_end", rx_valid, 1'b0);
    rx_ready = 1'b0;

    // glitch rejection
    cfg_divider = 32'd0; loads0 = loads; fe0 = fe_cnt;
    repeat (4) @(posedge clk);
    #1; rx = 1'b0;
    repeat (3) @(posedge clk);
    #1; rx = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("glitch_busy", rx_busy, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    chk("glitch_idle", rx_busy, 1'b0);
    chk("glitch_noload", loads - loads0, 0);
    chk("glitch_noferr", fe_cnt - fe0, 0);
    sbq.push_back(8'hFF);
    send_byte(8'hFF, 1'b1, 16, 4, 8);
    repeat (5) @(posedge clk);
    #1;
    chk("spike_load", loads - loads0, 1);
    drain();

    // framing error then break
    loads0 = loads; fe0 = fe_cnt;
    send_byte(8'h55, 1'b0, 16, -1, 0);
    rx = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("frame_ferr", fe_cnt - fe0, 1);
    chk("frame_noload", loads - loads0, 0);
    chk("frame_idle", rx_busy, 1'b0);
    fe0 = fe_cnt;
    @(posedge clk); #1; rx = 1'b0;
    repeat (640) @(posedge clk);
    #1; rx = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("break_ferr", fe_cnt - fe0, 1);
    chk("break_idle", rx_busy, 1'b0);
    sbq.push_back(8'h33);
    send_byte(8'h33, 1'b1, 16, -1, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("break_after_load", loads - loads0, 1);
    drain();

    // disable mid-frame
    loads0 = loads; fe0 = fe_cnt;
    fork
      send_byte(8'h7E, 1'b1, 16, -1, 0);
      begin
        @(posedge clk);
        repeat (60) @(posedge clk);
        #1;
        chk("dis_busy_before", rx_busy, 1'b1);
        cfg_divider = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        chk("dis_busy", rx_busy, 1'b0);
        chk("dis_valid", rx_valid, 1'b0);
      end
    join
    repeat (20) @(posedge clk);
    #1;
    chk("dis_busy_hold", rx_busy, 1'b0);
    cfg_divider = 32'd0;
    repeat (10) @(posedge clk);
    #1;
    chk("dis_noload", loads - loads0, 0);
    chk("dis_noferr", fe_cnt - fe0, 0);

    // overrun
    ov0 = ov_cnt;
    sbq.push_back(8'h11);
    send_byte(8'h11, 1'b1, 16, -1, 0);
    send_byte(8'h22, 1'b1, 16, -1, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("ovr_pulse", ov_cnt - ov0, 1);
    chk("ovr_data", rx_data, 8'h11);
    chk("ovr_valid", rx_valid, 1'b1);
    drain();

    // accept in the cycle the next byte completes
    ov0 = ov_cnt;
    sbq.push_back(8'h11);
    send_byte(8'h11, 1'b1, 16, -1, 0);
    sbq.push_back(8'h22);
    fork
      send_byte(8'h22, 1'b1, 16, -1, 0);
      begin
        @(posedge clk);
        repeat (154) @(posedge clk);
        #1; rx_ready = 1'b1;
        @(posedge clk); #1; rx_ready = 1'b0;
      end
    join
    #1;
    chk("simul_data", rx_data, 8'h22);
    chk("simul_valid", rx_valid, 1'b1);
    chk("simul_noovr", ov_cnt - ov0, 0);

    // reset mid-frame with 0x22 still held
    loads0 = loads;
    fork
      send_byte(8'hF0, 1'b1, 16, -1, 0);
      begin
        @(posedge clk);
        repeat (90) @(posedge clk);
        #1;
        chk("mrst_busy_before", rx_busy, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mrst_data", rx_data, 8'h00);
        chk("mrst_valid", rx_valid, 1'b0);
        chk("mrst_busy", rx_busy, 1'b0);
        chk("mrst_ferr", rx_frame_err, 1'b0);
        chk("mrst_ovr", rx_overrun, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
      end
    join
    repeat (5) @(posedge clk);
    #1;
    chk("mrst_idle", rx_busy, 1'b0);
    chk("mrst_noload", loads - loads0, 0);
    sbq.push_back(8'h3C);
    send_byte(8'h3C, 1'b1, 16, -1, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_load", loads - loads0, 1);
    chk("post_rst_data", rx_data, 8'h3C);
    chk("post_rst_valid", rx_valid, 1'b1);
    drain();

    chk("sb_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
